// File: rtl/clock_gate_pkg.sv
// clock_gate_pkg: shared types and constants for the clock-gate controller.
//   cg_state_e          per-channel FSM state (OFF, WAKE, ON, HOLD), 2-bit
//   CG_CNT_W            width of the wake/idle counters
//   CG_NUM_CH           number of gated channels
//   CG_WAKE_CYCLES_DEF  default gate-rise to ack-rise delay
//   CG_IDLE_CYCLES_DEF  default request-drop to gate-fall delay
package clock_gate_pkg;

    localparam int CG_CNT_W           = 8;
    localparam int CG_NUM_CH          = 3;
    localparam int CG_WAKE_CYCLES_DEF = 2;
    localparam int CG_IDLE_CYCLES_DEF = 8;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        WAKE = 2'd1,
        ON   = 2'd2,
        HOLD = 2'd3
    } cg_state_e;

endpackage

// File: rtl/clock_gate_chan.sv
// clock_gate_chan: one request/acknowledge channel FSM with its wake and
// idle counters.
//   clk       always-on clock
//   rst       synchronous reset, active-high
//   req       level request for this channel
//   gate_nxt  gate enable implied by the next state (registered by the top)
//   ack_nxt   acknowledge implied by the next state (registered by the top)
//   act_nxt   next state is not OFF (feeds busy)
// The outputs are derived from the next state so that the single output
// register in the top changes on the same edge as the state itself.
module clock_gate_chan
    import clock_gate_pkg::*;
#(
    parameter int WAKE_CYCLES = CG_WAKE_CYCLES_DEF,
    parameter int IDLE_CYCLES = CG_IDLE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    output logic gate_nxt,
    output logic ack_nxt,
    output logic act_nxt
);

    localparam logic [CG_CNT_W-1:0] WAKE_LOAD = CG_CNT_W'(WAKE_CYCLES - 1);
    localparam logic [CG_CNT_W-1:0] IDLE_LOAD = CG_CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CG_CNT_W-1:0] CNT_ONE   = CG_CNT_W'(1);

    cg_state_e             state_q, state_d;
    logic [CG_CNT_W-1:0]   wake_cnt_q, wake_cnt_d;
    logic [CG_CNT_W-1:0]   idle_cnt_q, idle_cnt_d;

    always_comb begin
        state_d    = state_q;
        wake_cnt_d = wake_cnt_q;
        idle_cnt_d = idle_cnt_q;
        case (state_q)
            OFF: begin
                if (req) begin
                    state_d    = WAKE;
                    wake_cnt_d = WAKE_LOAD;
                end
            end
            // The wake always runs to completion; req only chooses where it lands.
            WAKE: begin
                if (wake_cnt_q != '0) begin
                    wake_cnt_d = wake_cnt_q - CNT_ONE;
                end else if (req) begin
                    state_d = ON;
                end else begin
                    state_d    = HOLD;
                    idle_cnt_d = IDLE_LOAD;
                end
            end
            ON: begin
                if (!req) begin
                    state_d    = HOLD;
                    idle_cnt_d = IDLE_LOAD;
                end
            end
            // Clock is still running here, so a re-request skips the wake.
            HOLD: begin
                if (req) begin
                    state_d = ON;
                end else if (idle_cnt_q == '0) begin
                    state_d = OFF;
                end else begin
                    idle_cnt_d = idle_cnt_q - CNT_ONE;
                end
            end
            default: state_d = OFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= OFF;
            wake_cnt_q <= '0;
            idle_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wake_cnt_q <= wake_cnt_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

    assign gate_nxt = (state_d != OFF);
    assign ack_nxt  = (state_d == ON);
    assign act_nxt  = (state_d != OFF);

endmodule

// File: rtl/clock_gate_ctrl.sv
// clock_gate_ctrl: per-channel clock-gate enable generator.
//   clk       always-on clock
//   rst       synchronous reset, active-high (overrides everything)
//   req[2:0]  per-channel level request
//   ack[2:0]  per-channel clock-running acknowledge, registered
//   clkGate   per-channel gate enable to the gating block, registered
//   busy      any channel not in OFF, registered
//   force_on  only with CLOCK_GATE_FORCE_EN: opens all gates while high,
//             leaving the FSMs, ack and busy untouched
module clock_gate_ctrl
    import clock_gate_pkg::*;
#(
    parameter int WAKE_CYCLES = CG_WAKE_CYCLES_DEF,
    parameter int IDLE_CYCLES = CG_IDLE_CYCLES_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CG_NUM_CH-1:0] req,
`ifdef CLOCK_GATE_FORCE_EN
    input  logic                 force_on,
`endif
    output logic [CG_NUM_CH-1:0] ack,
    output logic [CG_NUM_CH-1:0] clkGate,
    output logic                 busy
);

    logic [CG_NUM_CH-1:0] gate_nxt, ack_nxt, act_nxt;
    logic [CG_NUM_CH-1:0] clk_gate_q, clk_gate_d;
    logic [CG_NUM_CH-1:0] ack_q, ack_d;
    logic                 busy_q, busy_d;

    for (genvar i = 0; i < CG_NUM_CH; i++) begin : g_chan
        clock_gate_chan #(
            .WAKE_CYCLES (WAKE_CYCLES),
            .IDLE_CYCLES (IDLE_CYCLES)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .req      (req[i]),
            .gate_nxt (gate_nxt[i]),
            .ack_nxt  (ack_nxt[i]),
            .act_nxt  (act_nxt[i])
        );
    end

    always_comb begin
`ifdef CLOCK_GATE_FORCE_EN
        clk_gate_d = gate_nxt | {CG_NUM_CH{force_on}};
`else
        clk_gate_d = gate_nxt;
`endif
        ack_d  = ack_nxt;
        busy_d = |act_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_gate_q <= '0;
            ack_q      <= '0;
            busy_q     <= 1'b0;
        end else begin
            clk_gate_q <= clk_gate_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
        end
    end

    assign clkGate = clk_gate_q;
    assign ack     = ack_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_clock_gate_ctrl.sv
// tb_clock_gate_ctrl: scoreboard bench for clock_gate_ctrl. Expected
// {clkGate, ack, busy} is pushed at each driven edge from an up-counting
// reference model and popped/compared half a cycle later.
module tb_clock_gate_ctrl;

    localparam int W = 2;
    localparam int I = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] req;
    logic       force_on;
    logic [2:0] ack;
    logic [2:0] clkGate;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [6:0] exp_q[$];

    // reference model: phase 0=off 1=waking 2=running 3=holding,
    // age counts edges since entering the phase
    int ph[3];
    int age[3];

    always #5 clk = ~clk;

    clock_gate_ctrl #(
        .WAKE_CYCLES (W),
        .IDLE_CYCLES (I)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
`ifdef CLOCK_GATE_FORCE_EN
        .force_on (force_on),
`endif
        .ack      (ack),
        .clkGate  (clkGate),
        .busy     (busy)
    );

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got gate=%b ack=%b busy=%b, want gate=%b ack=%b busy=%b",
                     tag, obs[6:4], obs[3:1], obs[0], exp_v[6:4], exp_v[3:1], exp_v[0]);
        end
    endtask

    task automatic model_edge(input logic [2:0] r, input logic rs, input logic f);
        logic [2:0] g, a;
        logic       f_eff;
        for (int i = 0; i < 3; i++) begin
            if (rs) begin
                ph[i] = 0; age[i] = 0;
            end else begin
                case (ph[i])
                    0: if (r[i]) begin ph[i] = 1; age[i] = 0; end
                    1: begin
                        age[i]++;
                        if (age[i] == W) begin ph[i] = r[i] ? 2 : 3; age[i] = 0; end
                    end
                    2: if (!r[i]) begin ph[i] = 3; age[i] = 0; end
                    default: begin
                        if (r[i]) ph[i] = 2;
                        else begin
                            age[i]++;
                            if (age[i] == I) begin ph[i] = 0; age[i] = 0; end
                        end
                    end
                endcase
            end
        end
`ifdef CLOCK_GATE_FORCE_EN
        f_eff = f;
`else
        f_eff = 1'b0;
`endif
        for (int i = 0; i < 3; i++) begin
            g[i] = !rs && ((ph[i] != 0) || f_eff);
            a[i] = (ph[i] == 2);
        end
        exp_q.push_back({g, a, (ph[0] != 0) || (ph[1] != 0) || (ph[2] != 0)});
    endtask

    // drive, let one edge happen, compare half a cycle later
    task automatic step(input string tag, input logic [2:0] r, input logic rs,
                        input logic f, input int n);
        logic [6:0] e;
        repeat (n) begin
            req = r; rst = rs; force_on = f;
            @(posedge clk);
            model_edge(r, rs, f);
            @(negedge clk);
            if (exp_q.size() == 0) begin
                chk({tag, "_sb_empty"}, 7'h7f, 7'h00);
            end else begin
                e = exp_q.pop_front();
                chk(tag, {clkGate, ack, busy}, e);
            end
        end
    endtask

    initial begin
        req = 3'b111; rst = 1'b1; force_on = 1'b0;
        for (int i = 0; i < 3; i++) begin ph[i] = 0; age[i] = 0; end
        @(negedge clk);

        step("reset_req111", 3'b111, 1'b1, 1'b0, 3);
        step("wake_all",     3'b111, 1'b0, 1'b0, 5);
        step("release_all",  3'b000, 1'b0, 1'b0, 12);

        step("pulse0_hi",    3'b001, 1'b0, 1'b0, 1);
        step("pulse0_lo",    3'b000, 1'b0, 1'b0, 12);

        step("ch1_on",       3'b010, 1'b0, 1'b0, 4);
        step("ch1_drop",     3'b000, 1'b0, 1'b0, 3);
        step("ch1_rereq",    3'b010, 1'b0, 1'b0, 3);
        step("ch1_release",  3'b000, 1'b0, 1'b0, 10);

        step("stag_001",     3'b001, 1'b0, 1'b0, 3);
        step("stag_011",     3'b011, 1'b0, 1'b0, 3);
        step("stag_010",     3'b010, 1'b0, 1'b0, 6);
        step("stag_000",     3'b000, 1'b0, 1'b0, 12);

        // channel 2 into HOLD, then 3 more edges leave idle_cnt at 4
        step("ch2_on",       3'b100, 1'b0, 1'b0, 4);
        step("ch2_hold",     3'b000, 1'b0, 1'b0, 4);
        step("ch2_rst",      3'b000, 1'b1, 1'b0, 1);
        step("ch2_after",    3'b000, 1'b0, 1'b0, 3);
        step("ch2_rewake",   3'b100, 1'b0, 1'b0, 4);
        step("ch2_idle",     3'b000, 1'b0, 1'b0, 10);

`ifdef CLOCK_GATE_FORCE_EN
        step("force_on",     3'b000, 1'b0, 1'b1, 3);
        step("force_off",    3'b000, 1'b0, 1'b0, 2);
        step("force_req",    3'b011, 1'b0, 1'b1, 4);
        step("force_rst",    3'b011, 1'b1, 1'b1, 1);
        step("force_drop",   3'b000, 1'b0, 1'b0, 12);
`endif

        for (int k = 0; k < 40; k++) begin
            step("random", 3'($urandom_range(0, 7)), ($urandom_range(0, 19) == 0),
                 1'b0, $urandom_range(1, 12));
        end
        step("drain", 3'b000, 1'b0, 1'b0, 12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

endmodule
